// File: rtl/special_move_pkg.sv
`default_nettype none
// ============================================================================
// Package : special_move_pkg
// Brief   : State encoding, default opcodes and execute-strobe bundle shared
//           by the special-move sequencer and later control-unit sequencers.
// Rev     : 1.0  initial release
// ============================================================================
package special_move_pkg;

    localparam int unsigned c_OPCODE_W = 5;

    localparam logic [4:0] c_OP_MFHI = 5'b10111;
    localparam logic [4:0] c_OP_MFLO = 5'b11000;
    localparam logic [4:0] c_OP_IN   = 5'b10110;
    localparam logic [4:0] c_OP_OUT  = 5'b10101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    typedef struct packed {
        logic gra;
        logic r_in;
        logic r_out;
        logic hi_out;
        logic lo_out;
        logic inport_out;
        logic outport_en;
    } exec_strobes_t;

endpackage
`default_nettype wire

// File: rtl/special_move_decode.sv
`default_nettype none
// ============================================================================
// Module : special_move_decode
// Brief  : Combinational execute-step decode of the register-move opcodes.
// Rev    : 1.0  initial release
// ============================================================================
module special_move_decode
    import special_move_pkg::*;
#(
    parameter int unsigned          OPCODE_W = c_OPCODE_W,
    parameter logic [OPCODE_W-1:0] OP_MFHI  = c_OP_MFHI,
    parameter logic [OPCODE_W-1:0] OP_MFLO  = c_OP_MFLO,
    parameter logic [OPCODE_W-1:0] OP_IN    = c_OP_IN,
    parameter logic [OPCODE_W-1:0] OP_OUT   = c_OP_OUT
) (
    input  logic                i_en,
    input  logic [OPCODE_W-1:0] i_opcode,
    output exec_strobes_t       o_strobes,
    output logic                o_legal,
    output logic                o_illegal
);

    always_comb begin
        o_strobes = '0;
        o_legal   = 1'b0;
        o_illegal = 1'b0;
        if (i_en) begin
            o_legal = 1'b1;
            if (i_opcode == OP_MFHI) begin
                o_strobes.gra    = 1'b1;
                o_strobes.r_in   = 1'b1;
                o_strobes.hi_out = 1'b1;
            end else if (i_opcode == OP_MFLO) begin
                o_strobes.gra    = 1'b1;
                o_strobes.r_in   = 1'b1;
                o_strobes.lo_out = 1'b1;
            end else if (i_opcode == OP_IN) begin
                o_strobes.gra        = 1'b1;
                o_strobes.r_in       = 1'b1;
                o_strobes.inport_out = 1'b1;
            end else if (i_opcode == OP_OUT) begin
                o_strobes.gra        = 1'b1;
                o_strobes.r_out      = 1'b1;
                o_strobes.outport_en = 1'b1;
            end else begin
                // Unsupported opcode: flag it but leave the register file untouched
                o_legal   = 1'b0;
                o_illegal = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/special_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module : special_move_ctrl
// Brief  : Fetch + register-move sequencer with memory-ready wait, timeout
//          halt, illegal-opcode flag and retired-instruction counter.
// Rev    : 1.0  initial release
// ============================================================================
module special_move_ctrl
    import special_move_pkg::*;
#(
    parameter int unsigned          OPCODE_W = c_OPCODE_W,
    parameter logic [OPCODE_W-1:0] OP_MFHI  = c_OP_MFHI,
    parameter logic [OPCODE_W-1:0] OP_MFLO  = c_OP_MFLO,
    parameter logic [OPCODE_W-1:0] OP_IN    = c_OP_IN,
    parameter logic [OPCODE_W-1:0] OP_OUT   = c_OP_OUT,
    parameter int unsigned          TIMEOUT  = 15,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Run,
    input  logic                Mem_ready,
    input  logic [OPCODE_W-1:0] IR_opcode,
    output logic                PCout,
    output logic                MAR_enable,
    output logic                ZLowIn,
    output logic                ZLowout,
    output logic                IncPC,
    output logic                PC_enable,
    output logic                MDR_read,
    output logic                MDR_enable,
    output logic                MDRout,
    output logic                IR_enable,
    output logic                Gra,
    output logic                R_in,
    output logic                R_out,
    output logic                HIout,
    output logic                LOout,
    output logic                InPortout,
    output logic                OutPort_enable,
    output logic                Busy,
    output logic                Done,
    output logic                Illegal,
    output logic                Mem_error,
    output logic [CNT_W-1:0]    Instr_count
);

    localparam int unsigned c_WAIT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_mem_error;
    logic [CNT_W-1:0]    r_count;
    logic                w_wait_expired;
    logic                w_dec_en;
    logic                w_legal;
    logic                w_illegal;
    exec_strobes_t       w_exec;

    // Current cycle is the last allowed T2 cycle without data
    assign w_wait_expired = (r_wait == c_WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_mem_error <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_T2 && !Mem_ready) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (r_state == ST_T2 && !Mem_ready && w_wait_expired) begin
                r_mem_error <= 1'b1;
            end
            if (w_legal) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        PCout      = 1'b0;
        MAR_enable = 1'b0;
        ZLowIn     = 1'b0;
        ZLowout    = 1'b0;
        IncPC      = 1'b0;
        PC_enable  = 1'b0;
        MDR_read   = 1'b0;
        MDR_enable = 1'b0;
        MDRout     = 1'b0;
        IR_enable  = 1'b0;
        w_dec_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Run) w_next = ST_T0;
            end
            ST_T0: begin
                PCout      = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                ZLowIn     = 1'b1;
                w_next     = ST_T1;
            end
            ST_T1: begin
                ZLowout   = 1'b1;
                PC_enable = 1'b1;
                MDR_read  = 1'b1;
                w_next    = ST_T2;
            end
            ST_T2: begin
                MDR_read   = 1'b1;
                MDR_enable = Mem_ready;
                if (Mem_ready)           w_next = ST_T3;
                else if (w_wait_expired) w_next = ST_HALT;
            end
            ST_T3: begin
                MDRout    = 1'b1;
                IR_enable = 1'b1;
                w_next    = ST_T4;
            end
            ST_T4: begin
                w_dec_en = 1'b1;
                w_next   = Run ? ST_T0 : ST_IDLE;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    special_move_decode #(
        .OPCODE_W (OPCODE_W),
        .OP_MFHI  (OP_MFHI),
        .OP_MFLO  (OP_MFLO),
        .OP_IN    (OP_IN),
        .OP_OUT   (OP_OUT)
    ) u_decode (
        .i_en      (w_dec_en),
        .i_opcode  (IR_opcode),
        .o_strobes (w_exec),
        .o_legal   (w_legal),
        .o_illegal (w_illegal)
    );

    assign Gra            = w_exec.gra;
    assign R_in           = w_exec.r_in;
    assign R_out          = w_exec.r_out;
    assign HIout          = w_exec.hi_out;
    assign LOout          = w_exec.lo_out;
    assign InPortout      = w_exec.inport_out;
    assign OutPort_enable = w_exec.outport_en;
    assign Busy           = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign Done           = w_legal;
    assign Illegal        = w_illegal;
    assign Mem_error      = r_mem_error;
    assign Instr_count    = r_count;

endmodule
`default_nettype wire
